sseg_bcd_converter: RTL
=======================

// Module: sseg_bcd_converter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) feeding the 7-segment digit
//  drivers. Takes the output-register value on a write strobe and produces DIGITS packed BCD digits
//  plus a sign flag. Replaces the combinational divide/modulo digit split and adds a signed display mode.
//  Sits between the CPU output register and the per-digit segment encoders.
// PARAMETERS
//  WIDTH   8  binary input width (bits)
//  DIGITS  3  BCD digits produced; must satisfy 10**DIGITS > 2**WIDTH (elaboration-time check)
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous, active-high reset
//  data_in      in   WIDTH       binary value to convert
//  wr           in   1           write strobe; data_in/signed_mode sampled on the rising clk edge
//  signed_mode  in   1           1: data_in is two's complement; 0: unsigned
//  bcd_out      out  4*DIGITS    packed BCD result; [3:0]=ones, [7:4]=tens, [11:8]=hundreds
//  neg_out      out  1           result is negative (signed_mode only)
//  valid        out  1           one-cycle pulse: bcd_out/neg_out just updated
//  busy         out  1           conversion in progress
// BEHAVIOUR
//  Reset (async, any state): bcd_out=0, neg_out=0, valid=0, busy=0, pending slot empty, FSM->IDLE.
//    Reset mid-conversion aborts; no valid pulse is issued for the aborted value.
//  FSM states: IDLE, CONV.
//  IDLE: busy=0. Start when wr=1 or pending slot full (the pending slot takes priority).
//    On start: mag = (signed_mode && data[WIDTH-1]) ? -data (mod 2**WIDTH) : data;
//    neg_q = signed_mode && data[WIDTH-1]; scratch BCD=0; cnt=0; next CONV.
//  CONV: busy=1. Each cycle: every scratch nibble >=5 gets +3, then {scratch,mag} shifts left 1.
//    cnt increments; on the WIDTH-th shift, the final scratch is registered into bcd_out,
//    neg_q into neg_out, valid=1 for that one cycle, FSM->IDLE.
//  Latency: wr sampled at edge E0 -> bcd_out/neg_out updated and valid high after edge E0+WIDTH
//    (8 cycles with the default WIDTH). busy is high from E0+1 through E0+WIDTH.
//  Outputs hold the last result between conversions; bcd_out never shows partial results.
//  wr while busy: data_in/signed_mode stored in a one-deep pending slot; a later wr while still busy
//    overwrites it (latest value wins). The pending slot starts in the cycle after valid, back to back:
//    the next valid follows exactly WIDTH+1 cycles after the previous one.
//  wr on the same edge that finishes a conversion: treated as wr while busy (goes to the pending slot).
//  Width: magnitude is WIDTH-bit unsigned. Signed most-negative input (0x80) -> mag 128, neg 1.
//    Unsigned max (0xFF) -> 255. Unused upper nibbles are always 0.
//  neg_out=1 with magnitude 0 is impossible; the -0 case does not exist.
// TESTING
//  1 rst, then wr data_in=0xFF signed_mode=0 -> after 8 cycles valid pulse, bcd_out=0x255, neg_out=0
//  2 wr 0xFF signed_mode=1 -> bcd_out=0x001, neg_out=1; wr 0x80 signed -> 0x128, neg_out=1;
//    wr 0x7F signed -> 0x127, neg_out=0
//  3 wr 0x00 -> bcd_out=0x000; sweep 0..255 unsigned and -128..127 signed against the reference model
//  4 wr 42, then wr 17 and wr 99 during busy -> valid with 0x042, then 9 cycles later valid with
//    0x099; 17 is dropped; exactly two valid pulses
//  5 wr 200, assert rst at cycle 4 -> bcd_out=0, busy=0, no valid; post-reset wr 7 -> 0x007 normally
//  6 hold wr=0 after result -> bcd_out/neg_out stable, valid stays 0, busy stays 0

Source files
------------

// File: rtl/sseg_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) for the 7-segment digit drivers.
// Latency: wr sampled at edge E0 -> bcd_out/neg_out/valid updated after edge E0+WIDTH.
// Backpressure: none; a wr while busy lands in a one-deep pending slot (latest value wins).
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   data_in      binary value, sampled with signed_mode when wr is high
//   signed_mode  1: data_in is two's complement, 0: unsigned
//   bcd_out      packed BCD result, [3:0]=ones, [7:4]=tens, [11:8]=hundreds, ...
//   neg_out      result is negative (only possible in signed mode)
//   valid        one-cycle pulse when bcd_out/neg_out update
//   busy         conversion in progress
module sseg_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                wr,
    input  logic                signed_mode,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                neg_out,
    output logic                valid,
    output logic                busy
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // The digit count must be able to represent every WIDTH-bit magnitude.
    generate
        if ((64'd10 ** DIGITS) <= (64'd1 << WIDTH)) begin : g_digits_check
            $error("sseg_bcd_converter: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mag;
    logic [BCD_W-1:0]   scratch;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q;

    logic               pend_vld;
    logic [WIDTH-1:0]   pend_dat;
    logic               pend_sgn;

    logic [WIDTH-1:0]   start_dat;
    logic               start_sgn;
    logic               start_neg;
    logic [WIDTH-1:0]   start_mag;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_nxt;
    logic [WIDTH-1:0]   mag_nxt;

    // Operand for a new conversion: a queued value always goes ahead of a fresh wr.
    always_comb begin
        start_dat = pend_vld ? pend_dat : data_in;
        start_sgn = pend_vld ? pend_sgn : signed_mode;
        start_neg = start_sgn & start_dat[WIDTH-1];
        // Two's-complement negate mod 2**WIDTH; the most-negative input maps to 2**(WIDTH-1).
        start_mag = start_neg ? (~start_dat + ONE) : start_dat;
    end

    // One double-dabble step: correct each nibble >= 5, then shift the magnitude MSB in.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        {scratch_nxt, mag_nxt} = {adj, mag} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mag      <= '0;
            scratch  <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            pend_vld <= 1'b0;
            pend_dat <= '0;
            pend_sgn <= 1'b0;
            bcd_out  <= '0;
            neg_out  <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;

            // The slot payload may be refreshed on any wr; pend_vld decides if it matters.
            if (wr) begin
                pend_dat <= data_in;
                pend_sgn <= signed_mode;
            end

            case (state)
                IDLE: begin
                    if (pend_vld || wr) begin
                        mag      <= start_mag;
                        neg_q    <= start_neg;
                        scratch  <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                        // A wr coinciding with a pending start waits in the slot.
                        pend_vld <= pend_vld & wr;
                    end
                end
                CONV: begin
                    mag     <= mag_nxt;
                    scratch <= scratch_nxt;
                    cnt     <= cnt + CNT_W'(1);
                    if (wr) begin
                        pend_vld <= 1'b1;
                    end
                    if (cnt == CNT_LAST) begin
                        bcd_out <= scratch_nxt;
                        neg_out <= neg_q;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
